// File: rtl/cic_pkg.sv
// Shared constants for the CIC decimation chain and a width helper for
// counters and pointers sized from a modulus.
package cic_pkg;

  localparam int unsigned CIC_WORD_BITS  = 12;
  localparam int unsigned CIC_DECIMATION = 4;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample handshake between the integrator section, the decimator and the
// first comb, plus the decimator's drop status.
interface cic_decimator_if #(
  parameter int unsigned W   = 12,
  parameter int unsigned DCB = 8
);
  logic [W-1:0]   in;
  logic           in_valid;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           out_ready;
  logic           overflow;
  logic [DCB-1:0] dropped_count;

  modport master (
    output in, in_valid, out_ready,
    input  out, out_valid, overflow, dropped_count
  );

  modport slave (
    input  in, in_valid, out_ready,
    output out, out_valid, overflow, dropped_count
  );
endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy counter and wrapping read/write pointers.
// Head data reads as zero while empty.
module sample_fifo
  import cic_pkg::*;
#(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = cnt_bits(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(Depth));
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (do_pop)
      rd_d = (rd_q == AW'(Depth - 1)) ? '0 : rd_q + AW'(1);
    if (do_push)
      wr_d = (wr_q == AW'(Depth - 1)) ? '0 : wr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cic_decimator.sv
// CIC rate-reduction stage: keeps one valid sample in every DecimationFactor,
// buffers kept samples for the comb and counts those lost to a full buffer.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int unsigned WordLengthBits   = CIC_WORD_BITS,
  parameter int unsigned DecimationFactor = CIC_DECIMATION,
  parameter int unsigned Phase            = 0,
  parameter int unsigned FifoDepth        = 2,
  parameter int unsigned DropCountBits    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  cic_decimator_if.slave bus
);
  localparam int unsigned PW = cnt_bits(DecimationFactor);

  logic [PW-1:0]            phase_q, phase_d;
  logic                     overflow_q, overflow_d;
  logic [DropCountBits-1:0] drop_cnt_q, drop_cnt_d;
  logic                     keep, push, pop, drop;
  logic                     fifo_full, fifo_empty;
  logic [WordLengthBits-1:0] head;

  assign keep = bus.in_valid && (phase_q == PW'(Phase));
  assign pop  = !fifo_empty && bus.out_ready;
  // A simultaneous pop frees the slot, so only a push without pop into a full FIFO drops.
  assign drop = keep && fifo_full && !pop;
  assign push = keep && !drop;

  always_comb begin
    phase_d    = phase_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.in_valid)
      phase_d = (phase_q == PW'(DecimationFactor - 1)) ? '0 : phase_q + PW'(1);
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DropCountBits'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sample_fifo #(
    .Width (WordLengthBits),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.in),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.out           = head;
  assign bus.out_valid     = !fifo_empty;
  assign bus.overflow      = overflow_q;
  assign bus.dropped_count = drop_cnt_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: one instance at Phase=0, one at Phase=3.
module tb_cic_decimator;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [11:0] q0[$];
  logic [11:0] q3[$];
  int          sel;

  logic        hold0 = 1'b0, hold3 = 1'b0;
  logic [11:0] prev0, prev3;

  always #5 clk = ~clk;

  cic_decimator_if #(.W(12), .DCB(8)) b0 ();
  cic_decimator_if #(.W(12), .DCB(8)) b3 ();

  cic_decimator #(
    .WordLengthBits(12), .DecimationFactor(4), .Phase(0),
    .FifoDepth(2), .DropCountBits(8)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  cic_decimator #(
    .WordLengthBits(12), .DecimationFactor(4), .Phase(3),
    .FifoDepth(2), .DropCountBits(8)
  ) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors: pop expected values whenever the DUT hands over a sample.
  always @(negedge clk) begin
    if (!rst_n) hold0 = 1'b0;
    else begin
      if (hold0) chk("hold0", {19'd0, b0.out_valid, b0.out}, {19'd0, 1'b1, prev0});
      if (b0.out_valid) begin
        if (b0.out_ready) begin
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop0 actual=%0h expected=none", b0.out);
          end else chk("data0", 32'(b0.out), 32'(q0.pop_front()));
        end
      end else chk("idle0", 32'(b0.out), 32'd0);
      hold0 = b0.out_valid && !b0.out_ready;
      prev0 = b0.out;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) hold3 = 1'b0;
    else begin
      if (hold3) chk("hold3", {19'd0, b3.out_valid, b3.out}, {19'd0, 1'b1, prev3});
      if (b3.out_valid) begin
        if (b3.out_ready) begin
          if (q3.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop3 actual=%0h expected=none", b3.out);
          end else chk("data3", 32'(b3.out), 32'(q3.pop_front()));
        end
      end else chk("idle3", 32'(b3.out), 32'd0);
      hold3 = b3.out_valid && !b3.out_ready;
      prev3 = b3.out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r);
    b0.out_ready = r;
    b3.out_ready = r;
  endtask

  task automatic send(input int unsigned d, input logic v);
    b0.in       = 12'(d);
    b3.in       = 12'(d);
    b0.in_valid = v && (sel == 0);
    b3.in_valid = v && (sel == 3);
    step();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q3.size() == 0) break;
      step();
    end
    chk(name, 32'(q0.size() + q3.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 0;
    rst_n = 1'b0;
    b0.in = 12'hAAA; b3.in = 12'hAAA;
    b0.in_valid = 1'b1; b3.in_valid = 1'b1;
    set_ready(1'b0);

    // Held reset ignores inputs.
    for (int i = 0; i < 1000; i++) begin
      step();
      chk("rst_out0", 32'(b0.out), 32'd0);
      chk("rst_valid0", 32'(b0.out_valid), 32'd0);
      chk("rst_ovf0", 32'(b0.overflow), 32'd0);
      chk("rst_drop0", 32'(b0.dropped_count), 32'd0);
      chk("rst_out3", 32'(b3.out), 32'd0);
      chk("rst_valid3", 32'(b3.out_valid), 32'd0);
    end
    b0.in_valid = 1'b0; b3.in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Continuous ramp.
    set_ready(1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) q0.push_back(12'(k));
      send(k, 1'b1);
    end
    send(0, 1'b0);
    drain("drain_ramp");

    // Ramp with idle cycles in between.
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) q0.push_back(12'(k));
      send(k, 1'b1);
      send(12'hFFF, 1'b0);
    end
    drain("drain_gaps");

    // Overflow with downstream stalled.
    set_ready(1'b0);
    q0.push_back(12'd0);
    q0.push_back(12'd4);
    for (int k = 0; k < 16; k++) send(k, 1'b1);
    send(0, 1'b0);
    chk("ovf_set", 32'(b0.overflow), 32'd1);
    chk("ovf_count", 32'(b0.dropped_count), 32'd2);
    chk("ovf_head", 32'(b0.out), 32'd0);
    set_ready(1'b1);
    drain("drain_ovf");
    step();
    chk("ovf_sticky", 32'(b0.overflow), 32'd1);
    chk("ovf_empty", 32'(b0.out_valid), 32'd0);

    // Simultaneous push and pop on a full FIFO.
    reset_pulse();
    chk("clr_ovf", 32'(b0.overflow), 32'd0);
    set_ready(1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k % 4 == 0) q0.push_back(12'(k));
      set_ready(k == 8);
      send(k, 1'b1);
    end
    set_ready(1'b0);
    send(0, 1'b0);
    chk("pp_drop", 32'(b0.dropped_count), 32'd0);
    chk("pp_ovf", 32'(b0.overflow), 32'd0);
    chk("pp_head", {19'd0, b0.out_valid, b0.out}, {19'd0, 1'b1, 12'd4});
    set_ready(1'b1);
    drain("drain_pp");

    // Phase=3 instance.
    reset_pulse();
    sel = 3;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 3) q3.push_back(12'(k));
      send(k, 1'b1);
    end
    send(0, 1'b0);
    drain("drain_ph3");

    // Reset mid-stream discards the buffered sample 3.
    set_ready(1'b0);
    for (int k = 0; k < 4; k++) send(k, 1'b1);
    b3.in_valid = 1'b0;
    chk("pre_rst_valid3", 32'(b3.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out3", 32'(b3.out), 32'd0);
    chk("mid_rst_valid3", 32'(b3.out_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    set_ready(1'b1);
    q3.push_back(12'd103);
    q3.push_back(12'd107);
    for (int k = 100; k < 108; k++) send(k, 1'b1);
    send(0, 1'b0);
    drain("drain_post_rst");
    chk("post_rst_ovf3", 32'(b3.overflow), 32'd0);
    chk("idle_dut0", 32'(b0.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Rate-reduction stage of the CIC decimation chain. Sits between the integrator section and the first comb.
- Keeps one input sample in every DecimationFactor valid samples and drops the rest.
- Buffers kept samples in a small FIFO and presents them to the comb over an out_valid/out_ready handshake.
- The integrators cannot stall, so there is no in_ready. Samples that arrive while the FIFO is full are dropped and reported.

Parameters:
- WordLengthBits, 12, width of in and out (two's complement, passed through unmodified).
- DecimationFactor, 4, R; keep 1 of every R valid inputs; legal range 2..1024.
- Phase, 0, counter value at which a sample is kept; legal range 0..R-1.
- FifoDepth, 2, number of kept samples buffered; legal range 1..16.
- DropCountBits, 8, width of the saturating drop counter.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WordLengthBits  signed sample from the integrator chain.
- in_valid  input  1  in carries a new sample this cycle.
- out  output  WordLengthBits  FIFO head sample; 0 when the FIFO is empty.
- out_valid  output  1  high while the FIFO is non-empty.
- out_ready  input  1  downstream accepts out this cycle.
- overflow  output  1  sticky; set on the first dropped kept sample.
- dropped_count  output  DropCountBits  saturating count of dropped kept samples.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release):
  - phase counter = 0; FIFO empty; out = 0, out_valid = 0, overflow = 0, dropped_count = 0.
  - All outputs hold these values for as long as rst_n is low, regardless of in_valid and out_ready.
- Phase counter:
  - Range 0..R-1. Advances by 1 only on a clock edge where in_valid = 1, and wraps R-1 -> 0.
  - Cycles with in_valid = 0 leave it unchanged.
- Keep decision: a sample is kept when in_valid = 1 and the counter equals Phase on that edge. Every other valid sample is discarded silently; this is not a drop.
- Push: a kept sample is written to the FIFO tail on that edge.
- Pop: on any edge with out_valid = 1 and out_ready = 1, the head is removed.
- Latency: a kept sample appears on out with out_valid = 1 immediately after the accepting edge (1 cycle) when the FIFO was empty. Otherwise it appears in FIFO order.
- Full FIFO:
  - Push with no pop on the same edge: the sample is dropped, overflow sets to 1, and dropped_count increments (saturating at all-ones).
  - Push and pop on the same edge: both occur, occupancy is unchanged, nothing is dropped.
- Empty FIFO with a push: out_valid rises on the next cycle. There is no combinational in-to-out bypass.
- out_valid stays high with out stable while out_ready = 0. It never deasserts without a pop.
- overflow clears only on reset.
- Reset mid-operation discards FIFO contents and restarts phase at 0. The first valid sample after release is kept when Phase = 0.

Decomposition:
- Package cic_pkg: shared constants for the CIC chain (default WordLengthBits, DecimationFactor) and a clog2-based width helper for the counter and FIFO pointers.
- Sub-module sample_fifo: synchronous FIFO parameterised by width and depth.
  - Ports: push, pop, data in/out, full, empty.
  - Occupancy counter plus read/write pointers with wrap.
- cic_decimator itself contains the phase counter, keep logic and drop accounting.

Test Plan (W=12, R=4, Phase=0, FifoDepth=2 unless stated):
- Hold rst_n=0; in=12'hAAA, in_valid=1, out_ready=0 for 1000 cycles -> out=0, out_valid=0, overflow=0, dropped_count=0 throughout.
- out_ready=1, in_valid=1, in ramps 0..15 one per cycle -> out_valid pulses one cycle each, with out = 0, 4, 8, 12 one cycle after the accepting edge; out=0 otherwise.
- Ramp 0..15 with in_valid=0 on every other cycle -> same output sequence 0, 4, 8, 12; phase advances only on valid cycles.
- out_ready=0; feed ramp 0..15 -> FIFO holds 0, 4 and 8, 12 are dropped, giving overflow=1 and dropped_count=2. Then set out_ready=1 -> out 0 then 4, then out_valid=0; overflow stays 1.
- Fill the FIFO with 0, 4. On the edge that keeps 8, set out_ready=1 for that cycle only -> pop of 0 and push of 8; FIFO then holds 4, 8; dropped_count=0.
- Phase=3: ramp 0..15 with out_ready=1 -> out = 3, 7, 11, 15. Pulse rst_n low mid-stream -> out=0, out_valid=0, FIFO empty; next kept sample is the 4th valid input after release.
